// File: rtl/spi_pkg.sv
// Shared SPI command encodings, frame widths and master FSM states.
// Combinational definitions only; no latency.
// No flow control; the slave-side FSM reuses these command constants.
package spi_pkg;
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        RECV,
        GAP
    } state_t;
endpackage

// File: rtl/spi_master.sv
// SPI master: shifts {cmd,data} frames out on MOSI under SS_n, captures rd-data bytes from MISO.
// Latency: done 12 cycles after accept for writes/rd-addr, 20+RD_WAIT cycles for rd-data.
// Backpressure: busy stays high until the last GAP cycle; start while busy is dropped, not queued.
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int GAP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS_n
);

    localparam logic [3:0] WAIT_LD = 4'(RD_WAIT - 1);
    localparam logic [3:0] GAP_LD  = 4'(GAP - 1);

    state_t               state, state_nxt;
    logic [3:0]           cnt, cnt_nxt, cnt_dec;
    logic [FRAME_W-1:0]   frame;
    logic [DATA_W-1:0]    rx;
    logic [1:0]           cmd_q;
    logic                 mosi_nxt, frame_ld, rx_shift, rdata_ld;
    logic                 ss_n_nxt, busy_nxt, done_nxt, rv_nxt;

    assign cnt_dec = cnt - 4'd1;

    // Outputs are computed for the state being entered so MOSI/SS_n leave flops directly.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mosi_nxt  = 1'b0;
        frame_ld  = 1'b0;
        rx_shift  = 1'b0;
        rdata_ld  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETUP;
                    frame_ld  = 1'b1;
                    mosi_nxt  = cmd[1];
                end
            end
            SETUP: begin
                state_nxt = SHIFT;
                cnt_nxt   = 4'd9;
                mosi_nxt  = frame[9];
            end
            SHIFT: begin
                if (cnt == 4'd0) begin
                    if (cmd_q == CMD_RD_DATA) begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_LD;
                    end else begin
                        state_nxt = spi_pkg::GAP;
                        cnt_nxt   = GAP_LD;
                    end
                end else begin
                    cnt_nxt  = cnt_dec;
                    mosi_nxt = frame[cnt_dec];
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RECV;
                    cnt_nxt   = 4'd7;
                end else begin
                    cnt_nxt = cnt_dec;
                end
            end
            RECV: begin
                rx_shift = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = spi_pkg::GAP;
                    cnt_nxt   = GAP_LD;
                    rdata_ld  = 1'b1;
                end else begin
                    cnt_nxt = cnt_dec;
                end
            end
            spi_pkg::GAP: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt_dec;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase

        ss_n_nxt = !(state_nxt inside {SETUP, SHIFT, WAIT, RECV});
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == spi_pkg::GAP) && (state != spi_pkg::GAP);
        rv_nxt   = done_nxt && (cmd_q == CMD_RD_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            frame       <= '0;
            rx          <= '0;
            cmd_q       <= CMD_WR_ADDR;
            rdata       <= 8'h00;
            MOSI        <= 1'b0;
            SS_n        <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            MOSI        <= mosi_nxt;
            SS_n        <= ss_n_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            rdata_valid <= rv_nxt;
            if (frame_ld) begin
                frame <= {cmd, wdata};
                cmd_q <= cmd;
            end
            if (rx_shift) rx <= {rx[DATA_W-2:0], MISO};
            if (rdata_ld) rdata <= {rx[DATA_W-2:0], MISO};
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboarded bench for spi_master with a behavioural slave/RAM stub on the pins,
// plus a second instance built with GAP=3 for inter-frame spacing.
module tb_spi_master;
    import spi_pkg::*;

    localparam int RD_W     = 2;
    localparam int GAP_MAIN = 1;

    logic       clk = 1'b0;
    logic       rst_n, start, start3;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       busy, done, rdata_valid, mosi, miso, ss_n;
    logic [7:0] rdata;
    logic       busy3, done3, rv3, mosi3, ss3;
    logic       miso3 = 1'b0;
    logic [7:0] rdata3;

    always #5 clk = ~clk;

    spi_master #(.RD_WAIT(RD_W), .GAP(GAP_MAIN)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .rdata_valid(rdata_valid),
        .MOSI(mosi), .MISO(miso), .SS_n(ss_n)
    );

    spi_master #(.RD_WAIT(RD_W), .GAP(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .cmd(cmd), .wdata(wdata),
        .busy(busy3), .done(done3), .rdata(rdata3), .rdata_valid(rv3),
        .MOSI(mosi3), .MISO(miso3), .SS_n(ss3)
    );

    int vectors = 0;
    int errs    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       rv;
        int         lat;
        int         low;
    } exp_t;
    exp_t sb[$];

    // Reference RAM model, advanced from the stimulus side only.
    logic [7:0] ref_mem [256];
    logic [7:0] ref_waddr = 8'h00, ref_raddr = 8'h00, ref_rdata = 8'h00;

    task automatic push(input logic [1:0] c, input logic [7:0] d);
        exp_t e;
        case (c)
            CMD_WR_ADDR: ref_waddr = d;
            CMD_WR_DATA: ref_mem[ref_waddr] = d;
            CMD_RD_ADDR: ref_raddr = d;
            default:     ref_rdata = ref_mem[ref_raddr];
        endcase
        e.cmd   = c;
        e.wdata = d;
        e.rdata = ref_rdata;
        e.rv    = (c == CMD_RD_DATA);
        e.lat   = e.rv ? 20 + RD_W : 12;
        e.low   = e.rv ? 11 + RD_W + 8 : 11;
        sb.push_back(e);
    endtask

    // Slave/RAM stub: low cycle 1 is setup, 2..11 carry frame bits, read byte follows the turnaround.
    logic [7:0] s_mem [256];
    logic [7:0] s_waddr = 8'h00, s_raddr = 8'h00, s_rbyte = 8'h00;
    logic [9:0] s_frame = '0;
    int         s_cnt = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            s_mem[i]   = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
        miso = 1'b0;
    end

    always @(negedge clk) begin
        int         k;
        logic [9:0] fr;
        if (ss_n) begin
            s_cnt <= 0;
            miso  <= 1'b0;
        end else begin
            k  = s_cnt + 1;
            fr = {s_frame[8:0], mosi};
            s_cnt <= k;
            if (k >= 2 && k <= 11) s_frame <= fr;
            if (k == 11) begin
                case (fr[9:8])
                    2'b00:   s_waddr <= fr[7:0];
                    2'b01:   s_mem[s_waddr] <= fr[7:0];
                    2'b10:   s_raddr <= fr[7:0];
                    default: s_rbyte <= s_mem[s_raddr];
                endcase
            end
            if (k >= 12 + RD_W && k <= 19 + RD_W)
                miso <= s_rbyte[7 - (k - 12 - RD_W)];
            else
                miso <= 1'b0;
        end
    end

    // Output monitor and scoreboard pop for both instances.
    int          cyc = 0, t_acc = 0, hi_run = 0, low_cnt = 0;
    logic [31:0] mosi_sh = '0;
    logic        prev_ss = 1'b1, b2b = 1'b0, b2b_seen = 1'b0;
    int          hi3 = 0, f3 = 0, d3 = 0;
    logic        prev3 = 1'b1;
    exp_t        e_pop;
    logic [31:0] em;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            prev_ss  <= 1'b1;
            hi_run   <= 0;
            low_cnt  <= 0;
            mosi_sh  <= '0;
            b2b_seen <= 1'b0;
            prev3    <= 1'b1;
        end else begin
            if (start && !busy) t_acc <= cyc;
            if (!ss_n) begin
                hi_run <= 0;
                if (prev_ss) begin
                    low_cnt <= 1;
                    mosi_sh <= {31'b0, mosi};
                    if (b2b && b2b_seen) check("b2b_gap_cycles", hi_run, GAP_MAIN + 1);
                    b2b_seen <= b2b;
                end else begin
                    low_cnt <= low_cnt + 1;
                    mosi_sh <= {mosi_sh[30:0], mosi};
                end
            end else begin
                hi_run <= hi_run + 1;
                if (!b2b) b2b_seen <= 1'b0;
            end
            prev_ss <= ss_n;
            if (rdata_valid) check("rdata_valid_needs_done", done, 1);
            if (done) begin
                vectors++;
                assert (sb.size() > 0) else begin
                    errs++;
                    $error("FAIL done_unexpected: observed done with %0d pending expected 1+", sb.size());
                end
                if (sb.size() > 0) begin
                    e_pop = sb.pop_front();
                    em = 32'({e_pop.cmd[1], e_pop.cmd, e_pop.wdata}) << (e_pop.low - 11);
                    check("rdata_valid", rdata_valid, e_pop.rv);
                    check("rdata", rdata, e_pop.rdata);
                    check("start_to_done", cyc - t_acc, e_pop.lat);
                    check("ss_low_cycles", low_cnt, e_pop.low);
                    check("mosi_seq", mosi_sh, em);
                end
            end

            if (!ss3 && prev3) begin
                if (f3 > 0) check("gap3_hi_cycles", hi3, 4);
                f3 <= f3 + 1;
            end
            hi3   <= ss3 ? hi3 + 1 : 0;
            prev3 <= ss3;
            if (done3) d3 <= d3 + 1;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle_busy", busy, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] d);
        wait_idle();
        push(c, d);
        cmd   = c;
        wdata = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cmd   = ~c;
        wdata = ~d;
    endtask

    typedef struct { logic [1:0] c; logic [7:0] d; } stim_t;
    stim_t b2b_tab [4];

    initial begin
        b2b_tab[0] = '{2'b10, 8'h10};
        b2b_tab[1] = '{2'b11, 8'h00};
        b2b_tab[2] = '{2'b00, 8'h20};
        b2b_tab[3] = '{2'b01, 8'hC3};
        rst_n = 1'b0; start = 1'b0; start3 = 1'b0; cmd = 2'b00; wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", ss_n, 1);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_rdata_valid", rdata_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(2'b00, 8'h3C);
        drain();
        send(2'b11, 8'h00);
        drain();
        check("rdata_after_read", rdata, ref_rdata);

        // Abort a frame mid-shift; nothing from it may reach done.
        wait_idle();
        cmd = 2'b01; wdata = 8'h99; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_ss_low", ss_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ss_n", ss_n, 1);
        check("midrst_busy", busy, 0);
        check("midrst_mosi", mosi, 0);
        check("midrst_rdata", rdata, 8'h00);
        check("midrst_done", done, 0);
        ref_rdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(2'b00, 8'h10);
        send(2'b01, 8'h5A);
        send(2'b10, 8'h10);
        send(2'b11, 8'h00);
        drain();
        check("loop_rdata", rdata, 8'h5A);

        send(2'b01, 8'h77);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        drain();
        repeat (20) @(posedge clk);
        #1;
        check("no_extra_frame_busy", busy, 0);
        check("no_extra_frame_pending", sb.size(), 0);

        wait_idle();
        b2b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            push(b2b_tab[i].c, b2b_tab[i].d);
            cmd   = b2b_tab[i].c;
            wdata = b2b_tab[i].d;
            start = 1'b1;
            @(negedge clk);
            while (busy && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("b2b_accept_window", busy, 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        drain();
        b2b = 1'b0;
        check("rdata_hold_across_writes", rdata, ref_rdata);

        send(2'b10, 8'h20);
        send(2'b11, 8'h00);
        drain();
        check("final_read_rdata", rdata, 8'hC3);

        cmd = 2'b00; wdata = 8'h81;
        start3 = 1'b1;
        repeat (62) @(posedge clk);
        #1 start3 = 1'b0;
        begin
            int n = 0;
            while (busy3 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check("gap3_busy_idle", busy3, 0);
        check("gap3_frames", f3, 5);
        check("gap3_done_count", d3, 5);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Drives the system-clocked SPI slave/RAM subsystem from the host side. Serialises 10-bit command frames ({cmd[1:0], data[7:0]}) on MOSI under SS_n, and returns read bytes captured from MISO.
- Sits between a host/register interface and the top-level MOSI/MISO/SS_n pins. It is the initiator counterpart to the slave.
- MOSI, MISO and SS_n all change and are sampled on the same clk as the slave; there is no separate SCLK.

Parameters:
- RD_WAIT, 2, clk cycles between the last MOSI frame bit and the first MISO sample on a read-data command (slave RAM turnaround); legal range 1..7.
- GAP, 1, minimum clk cycles SS_n is held high between frames; legal range 1..7.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- cmd  in  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- wdata  in  8  address or data byte; payload is don't-care for cmd 11 but is still shifted.
- busy  out  1  high from the cycle after accept through the last GAP cycle.
- done  out  1  one-cycle pulse at end of frame.
- rdata  out  8  last byte received; updated only on rd-data frames.
- rdata_valid  out  1  one-cycle pulse coincident with done, rd-data frames only.
- MOSI  out  1  serial data to slave, MSB first.
- MISO  in  1  serial data from slave, MSB first.
- SS_n  out  1  active-low slave select.

Behaviour:
- Reset values: SS_n=1, MOSI=0, busy=0, done=0, rdata=8'h00, rdata_valid=0, state=IDLE, counter=0.
- Reset mid-frame: SS_n returns high immediately (asynchronously), with no done pulse.
- Registered outputs only; MOSI and SS_n come straight from flops.
- On accept, cmd and wdata are latched into a 10-bit shift register frame={cmd,wdata}; cmd is kept separately.
- FSM states:
  - IDLE: SS_n=1, MOSI=0. start=1 -> SETUP, busy=1.
  - SETUP (1 cycle): SS_n=0, MOSI=cmd[1] (slave read/write select bit) -> SHIFT, cnt=9.
  - SHIFT (10 cycles): MOSI=frame[cnt], cnt counts 9..0. At cnt=0: cmd==11 -> WAIT, cnt=RD_WAIT-1; otherwise -> GAP, cnt=GAP-1.
  - WAIT (RD_WAIT cycles): SS_n=0, MOSI=0. At cnt=0 -> RECV, cnt=7.
  - RECV (8 cycles): SS_n=0, MOSI=0; MISO sampled each cycle into rx shift register MSB first. At cnt=0 -> GAP, cnt=GAP-1, and rdata is loaded with the completed byte.
  - GAP (GAP cycles): SS_n=1, MOSI=0. done pulses (and rdata_valid for cmd 11) on the first GAP cycle. At cnt=0 -> IDLE, busy=0.
- Frame lengths with SS_n low: write or rd-addr = 11 cycles; rd-data = 11+RD_WAIT+8 cycles.
- start-to-done latency: 12 cycles (write/rd-addr); 20+RD_WAIT cycles (rd-data).
- start while busy=1 is ignored and not queued. start in the same cycle busy falls (last GAP cycle) is also ignored; the host must see busy=0 before asserting start.
- cmd/wdata changes after accept have no effect on the frame in flight.
- rdata holds its value across write frames and rd-addr frames.
- Counter is 3 bits for WAIT/GAP and 4 bits for SHIFT; share one 4-bit counter.

Decomposition:
- Shared package spi_pkg:
  - command encodings CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - FRAME_W=10, DATA_W=8;
  - master state enum {IDLE, SETUP, SHIFT, WAIT, RECV, GAP}.
  - The slave-side FSM reuses the same command constants.
- No sub-module; the FSM, counter and two shift registers fit in one module.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT -> SS_n=1, busy=0, MOSI=0 asynchronously; no done pulse; rdata=00.
- Write: start with cmd=00, wdata=8'h3C -> SS_n low exactly 11 cycles, MOSI sequence 0,0,0,0,0,1,1,1,1,0,0; done pulses 12 cycles after start; rdata_valid stays 0.
- Read-data with loopback stub driving MISO=8'hA5 after RD_WAIT=2: cmd=11 -> SS_n low 21 cycles; rdata=8'hA5; done and rdata_valid pulse together.
- Full loop against the slave/RAM: wr-addr 8'h10, wr-data 8'h5A, rd-addr 8'h10, rd-data -> rdata=8'h5A.
- Back-to-back: start held high continuously -> frames separated by SS_n high for exactly GAP (1) cycle plus the IDLE accept cycle; starts pulsed while busy=1 produce no extra frames.
- GAP=3 build: SS_n high ≥3 cycles between frames; done still pulses exactly once per frame.
